// File: rtl/mult_bus_pkg.sv
// Shared definitions for the multiplier/popcount bus initiator: peripheral
// register addresses, STATUS bit positions, sequencer states and access kinds.
package mult_bus_pkg;

   localparam logic [15:0] ADDR_A1     = 16'h037F;
   localparam logic [15:0] ADDR_A2     = 16'h0388;
   localparam logic [15:0] ADDR_W      = 16'h0390;
   localparam logic [15:0] ADDR_L      = 16'h0398;
   localparam logic [15:0] ADDR_STATUS = 16'h03A0;
   localparam logic [15:0] ADDR_CTRL   = 16'h03A1;

   localparam int STATUS_VALID_BIT = 0;
   localparam int STATUS_READY_BIT = 1;

   typedef enum logic [3:0] {
      ST_IDLE, ST_WR_A1, ST_WR_A2, ST_WR_CTRL, ST_POLL,
      ST_GAP, ST_RD_W0, ST_RD_W1, ST_RD_L, ST_FIN
   } state_t;

   typedef enum logic {
      ACC_RD = 1'b0,
      ACC_WR = 1'b1
   } access_t;

   typedef enum logic [1:0] {
      PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD
   } phase_t;

   // States in which the sequencer owns exactly one bus access.
   function automatic logic isAccessState(input state_t s);
      return s inside {ST_WR_A1, ST_WR_A2, ST_WR_CTRL, ST_POLL,
                       ST_RD_W0, ST_RD_W1, ST_RD_L};
   endfunction

endpackage

// File: rtl/bus_access_engine.sv
// Runs one SETUP / STROBE / HOLD access on the strobe bus. A new request is
// accepted while idle or during HOLD, so accesses can run back to back.
module bus_access_engine import mult_bus_pkg::*; #(
   parameter int STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        i_req,
   input  access_t     i_kind,
   input  logic [15:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_ack,
   output logic [31:0] o_rdata,
   output logic [15:0] o_saddress,
   output logic [31:0] o_sdata_out,
   output logic        o_srd,
   output logic        o_swr,
   input  logic [31:0] i_sdata_in
);

   localparam logic [7:0] LAST_STROBE = 8'(STROBE_CYCLES - 1);

   phase_t     r_phase;
   access_t    r_kind;
   logic [7:0] r_strobeCnt;

   // Access phase sequencing; reset drops the strobes at once and abandons any access.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_phase     <= PH_IDLE;
         r_kind      <= ACC_RD;
         r_strobeCnt <= '0;
         o_saddress  <= '0;
         o_sdata_out <= '0;
         o_srd       <= 1'b0;
         o_swr       <= 1'b0;
         o_rdata     <= '0;
      end else begin
         case (r_phase)
            PH_IDLE, PH_HOLD: begin
               if (i_req) begin
                  r_phase    <= PH_SETUP;
                  r_kind     <= i_kind;
                  o_saddress <= i_addr;
                  if (i_kind == ACC_WR) o_sdata_out <= i_wdata;
               end else begin
                  r_phase <= PH_IDLE;
               end
            end
            PH_SETUP: begin
               r_phase     <= PH_STROBE;
               r_strobeCnt <= '0;
               o_srd       <= (r_kind == ACC_RD);
               o_swr       <= (r_kind == ACC_WR);
            end
            PH_STROBE: begin
               if (r_strobeCnt == LAST_STROBE) begin
                  r_phase <= PH_HOLD;
                  o_srd   <= 1'b0;
                  o_swr   <= 1'b0;
                  if (r_kind == ACC_RD) o_rdata <= i_sdata_in;
               end else begin
                  r_strobeCnt <= r_strobeCnt + 8'd1;
               end
            end
            default: r_phase <= PH_IDLE;
         endcase
      end
   end

   assign o_ack = (r_phase == PH_HOLD);

endmodule

// File: rtl/mult_bus_initiator.sv
// Bus-master sequencer for one multiplier/popcount job: writes both operands
// and the start register, polls STATUS, then reads back product and ones-count.
module mult_bus_initiator import mult_bus_pkg::*; #(
   parameter int STROBE_CYCLES = 2,
   parameter int POLL_GAP      = 4,
   parameter int POLL_LIMIT    = 255
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        start,
   input  logic [23:0] arg_a,
   input  logic [23:0] arg_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_w,
   output logic [23:0] ones_cnt,
   output logic        overflow,
   output logic        timeout,
   output logic [15:0] saddress,
   output logic        srd,
   output logic        swr,
   output logic [31:0] sdata_out,
   input  logic [31:0] sdata_in
);

   localparam logic [7:0] LAST_GAP  = 8'(POLL_GAP - 1);
   localparam logic [7:0] LAST_POLL = 8'(POLL_LIMIT - 1);

   state_t      r_state;
   state_t      w_nextState;
   logic [23:0] r_argB;
   logic [7:0]  r_pollCnt;
   logic [7:0]  r_gapCnt;
   logic        w_req;
   access_t     w_kind;
   logic [15:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_ack;
   logic [31:0] w_rdata;
   logic        w_ready;
   logic        w_pollExhausted;

   assign w_ready         = w_rdata[STATUS_READY_BIT];
   assign w_pollExhausted = (r_pollCnt == LAST_POLL);
   assign busy            = (r_state != ST_IDLE) && (r_state != ST_FIN);
   assign done            = (r_state == ST_FIN);

   // Next-state decision; access states advance only on the engine's ack.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_nextState = ST_WR_A1;
         ST_WR_A1:   if (w_ack) w_nextState = ST_WR_A2;
         ST_WR_A2:   if (w_ack) w_nextState = ST_WR_CTRL;
         ST_WR_CTRL: if (w_ack) w_nextState = ST_POLL;
         ST_POLL: begin
            if (w_ack) begin
               if (w_ready)              w_nextState = ST_RD_W0;
               else if (w_pollExhausted) w_nextState = ST_FIN;
               else                      w_nextState = ST_GAP;
            end
         end
         ST_GAP:     if (r_gapCnt == LAST_GAP) w_nextState = ST_POLL;
         ST_RD_W0:   if (w_ack) w_nextState = ST_RD_W1;
         ST_RD_W1:   if (w_ack) w_nextState = ST_RD_L;
         ST_RD_L:    if (w_ack) w_nextState = ST_FIN;
         ST_FIN:     w_nextState = ST_IDLE;
         default:    w_nextState = ST_IDLE;
      endcase
   end

   // Issue the next access in the same cycle the state is entered, so the engine
   // chains accesses without idle cycles. Operand A goes straight from the input:
   // the engine's data register captures it on the accepting edge.
   always_comb begin
      w_req   = isAccessState(w_nextState) && (w_nextState != r_state);
      w_kind  = ACC_RD;
      w_addr  = ADDR_STATUS;
      w_wdata = 32'h0;
      case (w_nextState)
         ST_WR_A1:   begin w_kind = ACC_WR; w_addr = ADDR_A1;   w_wdata = {8'h0, arg_a};  end
         ST_WR_A2:   begin w_kind = ACC_WR; w_addr = ADDR_A2;   w_wdata = {8'h0, r_argB}; end
         ST_WR_CTRL: begin w_kind = ACC_WR; w_addr = ADDR_CTRL; w_wdata = 32'h1;          end
         ST_POLL:    w_addr = ADDR_STATUS;
         ST_RD_W0,
         ST_RD_W1:   w_addr = ADDR_W;
         ST_RD_L:    w_addr = ADDR_L;
         default:    w_addr = ADDR_STATUS;
      endcase
   end

   // State register plus job results, poll and gap counters.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= ST_IDLE;
         r_argB    <= '0;
         r_pollCnt <= '0;
         r_gapCnt  <= '0;
         result_w  <= '0;
         ones_cnt  <= '0;
         overflow  <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_argB    <= arg_b;
                  r_pollCnt <= '0;
                  result_w  <= '0;
                  ones_cnt  <= '0;
                  overflow  <= 1'b0;
                  timeout   <= 1'b0;
               end
            end
            ST_POLL: begin
               if (w_ack) begin
                  r_gapCnt <= '0;
                  if (w_ready)              overflow  <= ~w_rdata[STATUS_VALID_BIT];
                  else if (w_pollExhausted) timeout   <= 1'b1;
                  else                      r_pollCnt <= r_pollCnt + 8'd1;
               end
            end
            ST_GAP:  r_gapCnt <= r_gapCnt + 8'd1;
            ST_RD_W1: if (w_ack) result_w <= w_rdata;
            ST_RD_L:  if (w_ack) ones_cnt <= w_rdata[23:0];
            default: ;
         endcase
      end
   end

   bus_access_engine #(.STROBE_CYCLES(STROBE_CYCLES)) uEngine (
      .clk         (clk),
      .n_reset     (n_reset),
      .i_req       (w_req),
      .i_kind      (w_kind),
      .i_addr      (w_addr),
      .i_wdata     (w_wdata),
      .o_ack       (w_ack),
      .o_rdata     (w_rdata),
      .o_saddress  (saddress),
      .o_sdata_out (sdata_out),
      .o_srd       (srd),
      .o_swr       (swr),
      .i_sdata_in  (sdata_in)
   );

endmodule

// File: tb/tb_mult_bus_initiator.sv
// Directed bench for mult_bus_initiator with a behavioural peripheral model
// and a bus monitor that logs accesses and flags strobe protocol violations.
module tb_mult_bus_initiator;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        start = 1'b0;
   logic [23:0] arg_a = '0;
   logic [23:0] arg_b = '0;
   logic        busy, done, overflow, timeout, srd, swr;
   logic [31:0] result_w, sdata_out, sdata_in;
   logic [23:0] ones_cnt;
   logic [15:0] saddress;

   int assertCnt = 0;
   int failCnt   = 0;
   int jobCycle  = 0;
   int doneCycle = 0;
   int savedCnt  = 0;

   int   readyPoll = 1;
   logic slvValid  = 1'b1;

   int          cycleCnt = 0;
   int          pollSeen = 0;
   int          wSeen    = 0;
   int          busCnt   = 0;
   int          protoErr = 0;
   int          statusCycle [0:3];
   logic [15:0] busLog [0:15];
   logic [23:0] slvA = '0;
   logic [23:0] slvB = '0;
   logic        prevSrd = 1'b0;
   logic        prevSwr = 1'b0;
   logic [15:0] prevAddr = '0;
   logic [31:0] prevData = '0;
   logic [47:0] slvProduct;
   logic [15:0] expOrder [0:6];

   assign slvProduct = slvA * slvB;

   mult_bus_initiator dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .start     (start),
      .arg_a     (arg_a),
      .arg_b     (arg_b),
      .busy      (busy),
      .done      (done),
      .result_w  (result_w),
      .ones_cnt  (ones_cnt),
      .overflow  (overflow),
      .timeout   (timeout),
      .saddress  (saddress),
      .srd       (srd),
      .swr       (swr),
      .sdata_out (sdata_out),
      .sdata_in  (sdata_in)
   );

   always #5 clk = ~clk;

   // Peripheral read data: STATUS goes ready on poll number readyPoll, W lags one read.
   always_comb begin
      sdata_in = 32'h0;
      case (saddress)
         16'h03A0: if (readyPoll != 0 && pollSeen >= readyPoll) sdata_in = {30'h0, 1'b1, slvValid};
         16'h0390: sdata_in = (wSeen >= 2) ? slvProduct[31:0] : 32'hDEADBEEF;
         16'h0398: sdata_in = {8'h0, 24'($countones(slvProduct[31:0]))};
         default:  sdata_in = 32'h0;
      endcase
   end

   // Bus monitor: logs each access at strobe rise, captures operand writes, checks protocol.
   always @(posedge clk) begin
      cycleCnt++;
      if (start && !busy && n_reset) begin
         pollSeen = 0;
         wSeen    = 0;
         busCnt   = 0;
      end
      if ((srd || swr) && !(prevSrd || prevSwr)) begin
         if (busCnt < 16) busLog[busCnt] = saddress;
         busCnt++;
         if (srd && saddress == 16'h03A0) begin
            if (pollSeen < 4) statusCycle[pollSeen] = cycleCnt;
            pollSeen++;
         end
         if (srd && saddress == 16'h0390) wSeen++;
         if (swr && saddress == 16'h037F) slvA = sdata_out[23:0];
         if (swr && saddress == 16'h0388) slvB = sdata_out[23:0];
      end
      if (srd && swr) protoErr++;
      if ((srd || swr) && (prevSrd || prevSwr) && (saddress != prevAddr || sdata_out != prevData))
         protoErr++;
      prevSrd  = srd;
      prevSwr  = swr;
      prevAddr = saddress;
      prevData = sdata_out;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      jobCycle++;
   endtask

   // Pulse start for one cycle; returns in cycle 1 of the job.
   task automatic applyStimulus(input logic [23:0] a, input logic [23:0] b,
                                input int rp, input logic valid);
      arg_a     = a;
      arg_b     = b;
      readyPoll = rp;
      slvValid  = valid;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      jobCycle = 1;
   endtask

   task automatic waitDone(input int limit);
      while (done !== 1'b1 && jobCycle < limit) tick();
      checkOutput("done seen", {31'h0, done}, 32'h1);
      doneCycle = jobCycle;
   endtask

   initial begin
      expOrder[0] = 16'h037F; expOrder[1] = 16'h0388; expOrder[2] = 16'h03A1;
      expOrder[3] = 16'h03A0; expOrder[4] = 16'h0390; expOrder[5] = 16'h0390;
      expOrder[6] = 16'h0398;

      $display("[TB] reset state");
      repeat (3) tick();
      checkOutput("reset flags", {26'h0, busy, done, overflow, timeout, srd, swr}, 32'h0);
      checkOutput("reset result_w", result_w, 32'h0);
      checkOutput("reset ones_cnt", {8'h0, ones_cnt}, 32'h0);
      checkOutput("reset saddress", {16'h0, saddress}, 32'h0);
      n_reset = 1'b1;
      repeat (2) tick();

      $display("[TB] basic job 3 x 5");
      applyStimulus(24'd3, 24'd5, 1, 1'b1);
      checkOutput("basic busy", {31'h0, busy}, 32'h1);
      waitDone(100);
      checkOutput("basic done cycle", doneCycle, 32'd29);
      checkOutput("basic busy at done", {31'h0, busy}, 32'h0);
      checkOutput("basic result_w", result_w, 32'h0000000F);
      checkOutput("basic ones_cnt", {8'h0, ones_cnt}, 32'd4);
      checkOutput("basic overflow", {31'h0, overflow}, 32'h0);
      checkOutput("basic access count", busCnt, 32'd7);
      for (int i = 0; i < 7; i++) checkOutput("basic bus order", {16'h0, busLog[i]}, {16'h0, expOrder[i]});
      tick();
      checkOutput("basic done one cycle", {31'h0, done}, 32'h0);

      $display("[TB] overflow job");
      applyStimulus(24'hFFFFFF, 24'hFFFFFF, 1, 1'b0);
      waitDone(100);
      checkOutput("ovf result_w", result_w, 32'hFE000001);
      checkOutput("ovf ones_cnt", {8'h0, ones_cnt}, 32'd8);
      checkOutput("ovf overflow", {31'h0, overflow}, 32'h1);
      tick();

      $display("[TB] slow ready on third poll");
      applyStimulus(24'd3, 24'd5, 3, 1'b1);
      waitDone(200);
      checkOutput("slow done cycle", doneCycle, 32'd45);
      checkOutput("slow poll count", pollSeen, 32'd3);
      checkOutput("slow poll spacing 1", statusCycle[1] - statusCycle[0], 32'd8);
      checkOutput("slow poll spacing 2", statusCycle[2] - statusCycle[1], 32'd8);
      checkOutput("slow result_w", result_w, 32'h0000000F);
      checkOutput("slow overflow cleared", {31'h0, overflow}, 32'h0);
      tick();

      $display("[TB] timeout job");
      applyStimulus(24'd3, 24'd5, 0, 1'b1);
      waitDone(4000);
      checkOutput("tmo poll count", pollSeen, 32'd255);
      checkOutput("tmo timeout", {31'h0, timeout}, 32'h1);
      checkOutput("tmo result_w", result_w, 32'h0);
      checkOutput("tmo ones_cnt", {8'h0, ones_cnt}, 32'h0);
      checkOutput("tmo overflow", {31'h0, overflow}, 32'h0);
      checkOutput("tmo busy", {31'h0, busy}, 32'h0);
      tick();

      $display("[TB] start while busy");
      applyStimulus(24'd6, 24'd7, 2, 1'b1);
      repeat (13) tick();
      arg_a = 24'h000100;
      arg_b = 24'h000100;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("ignored start busy", {31'h0, busy}, 32'h1);
      waitDone(200);
      checkOutput("ignored start done cycle", doneCycle, 32'd37);
      checkOutput("ignored start result_w", result_w, 32'h0000002A);
      checkOutput("ignored start ones_cnt", {8'h0, ones_cnt}, 32'd3);
      checkOutput("ignored start timeout cleared", {31'h0, timeout}, 32'h0);
      checkOutput("ignored start access count", busCnt, 32'd8);
      checkOutput("ignored start A1 data", {8'h0, slvA}, 32'd6);
      checkOutput("ignored start A2 data", {8'h0, slvB}, 32'd7);
      tick();

      $display("[TB] reset during WR_A2 strobe");
      applyStimulus(24'd1, 24'd2, 1, 1'b1);
      repeat (5) tick();
      checkOutput("midrst swr before", {31'h0, swr}, 32'h1);
      checkOutput("midrst addr before", {16'h0, saddress}, 32'h0388);
      #2 n_reset = 1'b0;
      #1;
      checkOutput("midrst strobes async", {30'h0, srd, swr}, 32'h0);
      checkOutput("midrst busy", {31'h0, busy}, 32'h0);
      #1 n_reset = 1'b1;
      savedCnt = busCnt;
      repeat (20) tick();
      checkOutput("midrst no new access", busCnt, savedCnt);
      checkOutput("midrst idle after", {29'h0, busy, srd, swr}, 32'h0);

      $display("[TB] job after reset");
      applyStimulus(24'd3, 24'd5, 1, 1'b1);
      waitDone(100);
      checkOutput("post-reset done cycle", doneCycle, 32'd29);
      checkOutput("post-reset result_w", result_w, 32'h0000000F);
      tick();

      checkOutput("bus protocol violations", protoErr, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
